// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions.
// Default operand widths and the divider FSM state encoding.
package arith_pkg;

    localparam int DVD_W_DEF = 16;
    localparam int DVS_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/eight_bit_carry_ripple_adder.sv
// Eight-bit carry-ripple adder.
// The basic add cell reused by the arithmetic datapath.
module eight_bit_carry_ripple_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/restoring_div_step.sv
// One restoring-division iteration.
// Shifts the next dividend bit into the remainder, trial-subtracts the divisor and keeps or restores.
module restoring_div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] rem,
    input  logic         next_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    localparam int NB = (W + 7) / 8;
    localparam int PW = NB * 8;

    logic [W-1:0]  r_lo;
    logic [PW-1:0] a_pad;
    logic [PW-1:0] b_pad;
    logic [PW-1:0] sum_pad;
    logic [NB:0]   c;
    logic          no_borrow;

    assign r_lo  = {rem[W-2:0], next_bit};
    assign a_pad = PW'(r_lo);
    // Padding ones in b keep the final carry equal to the carry out of bit W-1.
    assign b_pad = ~PW'(divisor);
    assign c[0]  = 1'b1;

    for (genvar g = 0; g < NB; g++) begin : g_add
        eight_bit_carry_ripple_adder u_add (
            .a   (a_pad[g*8 +: 8]),
            .b   (b_pad[g*8 +: 8]),
            .cin (c[g]),
            .sum (sum_pad[g*8 +: 8]),
            .cout(c[g+1])
        );
    end

    assign no_borrow = rem[W-1] | c[NB];
    assign rem_out   = no_borrow ? sum_pad[W-1:0] : r_lo;
    assign q_bit     = no_borrow;

endmodule

// File: rtl/unsigned_sequential_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// Valid/ready request and result channels around a three-state FSM.
module unsigned_sequential_divider
    import arith_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVD_W-1:0] qr_q, qr_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [DVS_W-1:0] step_rem;
    logic             step_q;

    restoring_div_step #(.W(DVS_W)) u_step (
        .rem     (rem_q),
        .next_bit(qr_q[DVD_W-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        qr_d    = qr_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    if (divisor != '0) begin
                        qr_d    = dividend;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        cnt_d   = CNT_W'(DVD_W - 1);
                        state_d = CALC;
                    end else begin
                        qr_d    = '1;
                        rem_d   = dividend[DVS_W-1:0];
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                qr_d  = {qr_q[DVD_W-2:0], step_q};
                rem_d = step_rem;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            qr_q    <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            qr_q    <= qr_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = qr_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
